// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-lite transfer/response encodings and default-slave states
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb3lite_default_slave.sv
// rtl/ahb3lite_default_slave.sv - default slave answering unmapped transfers with a two-cycle ERROR
module ahb3lite_default_slave
  import ahb3lite_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q, state_d;
  logic      accept;

  assign accept = HREADY && HSEL && htrans_active(HTRANS);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs depend on state only, so the combined HREADY never loops back through here.
  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      DS_IDLE: begin
        if (accept) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP   = HRESP_ERROR;
        state_d = accept ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb3lite_decoder_mux.sv
// rtl/ahb3lite_decoder_mux.sv - single-master AHB3-lite address decoder, response mux and error capture
module ahb3lite_decoder_mux
  import ahb3lite_pkg::*;
#(
  parameter int                  NSLAVE = 2,
  parameter int                  AW     = 32,
  parameter int                  DW     = 32,
  parameter logic [NSLAVE*AW-1:0] BASE  = {32'hF000_0000, 32'h0000_0000},
  parameter logic [NSLAVE*AW-1:0] MASK  = {32'hF000_0000, 32'h8000_0000},
  parameter int                  CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [AW-1:0]        HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [DW-1:0]        HRDATA,
  output logic [NSLAVE-1:0]    HSEL_S,
  input  logic [NSLAVE-1:0]    HREADYOUT_S,
  input  logic [NSLAVE-1:0]    HRESP_S,
  input  logic [NSLAVE*DW-1:0] HRDATA_S,
  output logic [AW-1:0]        ERR_ADDR,
  output logic                 ERR_WRITE,
  output logic [CNT_W-1:0]     ERR_CNT,
  input  logic                 ERR_CLR
);

  logic [NSLAVE-1:0] hsel;
  logic              miss;
  logic [NSLAVE:0]   dsel_q, dsel_d;
  logic              ds_hreadyout, ds_hresp;
  logic              err_entry;
  logic [AW-1:0]     err_addr_q, err_addr_d;
  logic              err_write_q, err_write_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  // Lowest index wins on overlapping windows, keeping HSEL_S one-hot or zero.
  always_comb begin
    logic found;
    hsel  = '0;
    found = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (!found && ((HADDR & MASK[i*AW +: AW]) == BASE[i*AW +: AW])) begin
        hsel[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign miss   = ~|hsel;
  assign HSEL_S = hsel;

  assign dsel_d = HREADY ? {miss, hsel} : dsel_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dsel_q <= {1'b1, {NSLAVE{1'b0}}};
    end else begin
      dsel_q <= dsel_d;
    end
  end

  ahb3lite_default_slave u_default_slave (
    .CLK       (CLK),
    .RESET     (RESET),
    .HSEL      (miss),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (ds_hreadyout),
    .HRESP     (ds_hresp)
  );

  always_comb begin
    HREADY = ds_hreadyout;
    HRESP  = ds_hresp;
    HRDATA = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (dsel_q[i]) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
        HRDATA = HRDATA_S[i*DW +: DW];
      end
    end
  end

  // Same condition that moves the default slave into ERR1.
  assign err_entry = HREADY && miss && htrans_active(HTRANS);

  always_comb begin
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    err_cnt_d   = err_cnt_q;
    if (err_entry) begin
      err_addr_d  = HADDR;
      err_write_d = HWRITE;
    end else if (ERR_CLR) begin
      err_addr_d  = '0;
      err_write_d = 1'b0;
    end
    if (ERR_CLR) begin
      err_cnt_d = '0;
    end else if (err_entry && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ERR_ADDR  = err_addr_q;
  assign ERR_WRITE = err_write_q;
  assign ERR_CNT   = err_cnt_q;

endmodule
